// File: rtl/branch_predictor.sv
// branch_predictor: direct-mapped BTB with 2-bit counters, lookup/mispredict
// statistics, and an optional return address stack enabled by BP_RAS_EN.
// Lookup is combinational on if_pc; training happens at resolution time.
module branch_predictor #(
    parameter int ENTRIES   = 16,
    parameter int TAG_W     = 8,
    parameter int RAS_DEPTH = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        if_valid,
    input  logic [31:0] if_pc,
    output logic        pred_taken,
    output logic [31:0] pred_target,
    input  logic        upd_valid,
    input  logic [31:0] upd_pc,
    input  logic        upd_taken,
    input  logic [31:0] upd_target,
    input  logic [1:0]  upd_type,
    input  logic        upd_mispredict,
    output logic [31:0] stat_lookups,
    output logic [31:0] stat_mispredicts
);
    localparam int IDX_W = $clog2(ENTRIES);

    typedef struct packed {
        logic             valid;
        logic [TAG_W-1:0] tag;
        logic [31:0]      target;
        logic [1:0]       cnt;
        logic [1:0]       typ;
    } btb_entry_t;

    btb_entry_t btb [ENTRIES];

    logic [IDX_W-1:0] look_idx, upd_idx;
    logic [TAG_W-1:0] look_tag, upd_tag;
    btb_entry_t       look_e, upd_e, upd_next;
    logic             look_hit, upd_hit, upd_write;
    logic             ras_hit_ok;
    logic [31:0]      ras_top;

    assign look_idx = if_pc[IDX_W+1:2];
    assign look_tag = if_pc[IDX_W+TAG_W+1:IDX_W+2];
    assign upd_idx  = upd_pc[IDX_W+1:2];
    assign upd_tag  = upd_pc[IDX_W+TAG_W+1:IDX_W+2];
    assign look_e   = btb[look_idx];
    assign upd_e    = btb[upd_idx];
    assign look_hit = look_e.valid && (look_e.tag == look_tag);
    assign upd_hit  = upd_e.valid && (upd_e.tag == upd_tag);

    // Only the address bits that form index/tag are consumed by the BTB
    logic unused_bits;
    assign unused_bits = ^{if_pc, upd_pc, 1'(RAS_DEPTH)};

`ifdef BP_RAS_EN
    localparam int RP_W = (RAS_DEPTH > 1) ? $clog2(RAS_DEPTH) : 1;
    localparam int RC_W = $clog2(RAS_DEPTH + 1);

    logic [31:0]     ras [RAS_DEPTH];
    logic [RP_W-1:0] ras_ptr, ras_inc, ras_dec;
    logic [RC_W-1:0] ras_cnt;
    logic            ras_push, ras_pop;

    assign ras_inc  = (ras_ptr == RP_W'(RAS_DEPTH - 1)) ? '0 : ras_ptr + 1'b1;
    assign ras_dec  = (ras_ptr == '0) ? RP_W'(RAS_DEPTH - 1) : ras_ptr - 1'b1;
    assign ras_push = upd_valid && (upd_type == 2'b10);
    assign ras_pop  = upd_valid && (upd_type == 2'b11) && (ras_cnt != '0);
    assign ras_top  = ras[ras_ptr];
    assign ras_hit_ok = (ras_cnt != '0);

    // Return-address storage; a push when full simply overwrites the oldest slot
    always_ff @(posedge clk) begin
        if (ras_push) ras[ras_inc] <= upd_pc + 32'd4;
    end

    // Stack pointer and occupancy; count saturates at RAS_DEPTH
    always_ff @(posedge clk) begin
        if (!rst) begin
            ras_ptr <= '0;
            ras_cnt <= '0;
        end else if (ras_push) begin
            ras_ptr <= ras_inc;
            if (ras_cnt != RC_W'(RAS_DEPTH)) ras_cnt <= ras_cnt + 1'b1;
        end else if (ras_pop) begin
            ras_ptr <= ras_dec;
            ras_cnt <= ras_cnt - 1'b1;
        end
    end
`else
    assign ras_top    = '0;
    assign ras_hit_ok = 1'b0;
`endif

    // Combinational prediction; masked while reset is held so outputs are clean
    always_comb begin
        pred_taken  = rst && look_hit && ((look_e.typ != 2'b00) || look_e.cnt[1]);
        pred_target = if_pc + 32'd4;
        if (pred_taken) begin
            if ((look_e.typ == 2'b11) && ras_hit_ok) pred_target = ras_top;
            else                                    pred_target = look_e.target;
        end
    end

    // Next contents of the indexed entry for a resolved instruction
    always_comb begin
        upd_next  = upd_e;
        upd_write = 1'b0;
        if (upd_valid && upd_hit) begin
            upd_write       = 1'b1;
            upd_next.target = upd_target;
            upd_next.typ    = upd_type;
            if (upd_type != 2'b00)  upd_next.cnt = 2'b11;
            else if (upd_taken)     upd_next.cnt = (upd_e.cnt == 2'b11) ? 2'b11 : upd_e.cnt + 2'd1;
            else                    upd_next.cnt = (upd_e.cnt == 2'b00) ? 2'b00 : upd_e.cnt - 2'd1;
        end else if (upd_valid && upd_taken) begin
            upd_write       = 1'b1;
            upd_next.valid  = 1'b1;
            upd_next.tag    = upd_tag;
            upd_next.target = upd_target;
            upd_next.typ    = upd_type;
            upd_next.cnt    = (upd_type == 2'b00) ? 2'b10 : 2'b11;
        end
    end

    // BTB state; reset wins over a same-cycle update
    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int i = 0; i < ENTRIES; i++) btb[i] <= '0;
        end else if (upd_write) begin
            btb[upd_idx] <= upd_next;
        end
    end

    // Saturating statistics counters
    always_ff @(posedge clk) begin
        if (!rst) begin
            stat_lookups     <= '0;
            stat_mispredicts <= '0;
        end else begin
            if (if_valid && (stat_lookups != '1))
                stat_lookups <= stat_lookups + 32'd1;
            if (upd_valid && upd_mispredict && (stat_mispredicts != '1))
                stat_mispredicts <= stat_mispredicts + 32'd1;
        end
    end
endmodule

// File: doc/branch_predictor.md
# branch_predictor

Parametrised dynamic branch predictor for the 5-stage pipelined CPU. It sits beside the PC register in IF. Each cycle it looks up the current fetch PC and returns a predicted next PC, so taken branches and jumps no longer wait for MEM-stage resolution. It is trained at resolution time (MEM) from the resolved outcome. It holds:
- a direct-mapped BTB with 2-bit saturating counters;
- an optional return address stack (RAS);
- lookup and mispredict statistics counters.

## Interface
- ENTRIES, 16, BTB entries; power of two, ≥2; IDX_W = log2(ENTRIES).
- TAG_W, 8, tag width; tag = pc[IDX_W+TAG_W+1 : IDX_W+2].
- RAS_DEPTH, 4, RAS entries; ≥1; ignored without BP_RAS_EN.

- clk  in  1  main clock; all state changes on posedge.
- rst  in  1  reset, synchronous, active-low.
- if_valid  in  1  fetch lookup is real; gates stat_lookups only.
- if_pc  in  32  fetch PC; index = if_pc[IDX_W+1:2].
- pred_taken  out  1  predicted redirect.
- pred_target  out  32  predicted next PC; if_pc+4 when pred_taken=0.
- upd_valid  in  1  resolved control-flow instruction this cycle.
- upd_pc  in  32  PC of the resolved instruction.
- upd_taken  in  1  resolved direction; 1 for all jumps.
- upd_target  in  32  resolved target.
- upd_type  in  2  00 conditional branch, 01 j, 10 jal (call), 11 jr $31 (return).
- upd_mispredict  in  1  pipeline flushed for this instruction; counted when upd_valid=1.
- stat_lookups  out  32  count of if_valid cycles.
- stat_mispredicts  out  32  count of upd_valid & upd_mispredict.

## Operation
- BTB entry fields: valid, tag, target[31:0], cnt[1:0], type[1:0].
- Lookup is combinational on if_pc.
  - hit = valid & tag match.
  - pred_taken = hit & (type≠00 | cnt[1]).
  - pred_target selection:
    - type=11, pred_taken=1 and RAS non-empty: RAS top.
    - otherwise, pred_taken=1: entry target.
    - otherwise: if_pc+4 (32-bit wrap).
- Update (upd_valid=1), applied at posedge:
  - Hit, type 00: cnt saturating +1 if taken, -1 if not (floor 00, ceiling 11); target and type rewritten.
  - Hit, other types: target and type rewritten; cnt set to 11.
  - Miss and upd_taken=1: allocate/overwrite the indexed entry: valid=1, tag, target, type; cnt=10 for type 00, 11 otherwise.
  - Miss and upd_taken=0: no BTB change.
- RAS (BP_RAS_EN), updated at resolution:
  - upd_type=10 pushes upd_pc+4.
  - upd_type=11 pops.
  - Circular buffer: push when full overwrites the oldest entry and count stays at RAS_DEPTH.
  - Pop when empty: no-op.
- Statistics: both counters saturate at 32'hFFFF_FFFF.

## Timing
- Lookup latency 0 cycles, purely combinational from if_pc and state.
- An update is visible to lookups from the cycle after upd_valid.
- Same-cycle lookup and update of the same index: the lookup sees the old contents.
- Reset (rst=0 at posedge): all valid bits, cnt and type cleared; RAS count=0; both stats=0.
  - Outputs during and after reset: pred_taken=0, pred_target=if_pc+4.
  - Reset mid-training discards all learned state.
  - Reset has priority over a simultaneous update.
- No back-pressure; upd_valid is accepted every cycle.

## Configuration
- BP_RAS_EN defined: RAS is instantiated and return-type hits use the RAS top when non-empty.
- BP_RAS_EN undefined: no RAS storage.
  - Return-type hits predict the stored BTB target.
  - upd_type=10/11 still record the type in the BTB.
  - RAS_DEPTH is unused.

## Test plan
- Reset, lookup if_pc=0x40 → pred_taken=0, pred_target=0x44; both stats=0.
- Update pc=0x40, type 00, taken, target 0x80 → next-cycle lookup 0x40 gives pred_taken=1, target 0x80. Two not-taken updates → pred_taken=0, target 0x44.
- ENTRIES=16, TAG_W=8: train 0x40 taken → 0x80; lookup 0x440 (same index, different tag) → miss, target 0x444. Train 0x440 → lookup 0x40 now misses.
- BP_RAS_EN: BTB holds jr $31 at 0x2FC (target 0x300). Update jal at pc 0x100 → lookup 0x2FC gives target 0x104. Without BP_RAS_EN → 0x300.
- RAS_DEPTH=4: jal at 0x10, 0x20, 0x30, 0x40, 0x50, then five return updates, checking the predicted target at 0x2FC before each pop. Required sequence: 0x54, 0x44, 0x34, 0x24, then 0x300 (RAS empty).
- 40 if_valid cycles plus 3 mispredict updates → stat_lookups=40, stat_mispredicts=3. rst=0 for one cycle → both 0 and all lookups miss.
